alu_arbiter: RTL



---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu.sv | 31 +++
 rtl/alu_rr_pick.sv | 32 +++
 rtl/alu_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, datapath widths and arbiter FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] ADD = 3'b000;
    localparam logic [OP_W-1:0] SUB = 3'b001;
    localparam logic [OP_W-1:0] AND = 3'b010;
    localparam logic [OP_W-1:0] OR  = 3'b011;
    localparam logic [OP_W-1:0] XOR = 3'b100;
    localparam logic [OP_W-1:0] SLT = 3'b101;
    localparam logic [OP_W-1:0] SLL = 3'b110;
    localparam logic [OP_W-1:0] SRL = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU; SLT is unsigned, shifts use b[4:0].
// Latency: 0 cycles (combinational).
// Backpressure: none.
module alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic              zero
);

    always_comb begin
        c = '0;
        case (alu_op)
            ADD:     c = a + b;
            SUB:     c = a - b;
            AND:     c = a & b;
            OR:      c = a | b;
            XOR:     c = a ^ b;
            SLT:     c = {{(DATA_W-1){1'b0}}, (a < b)};
            SLL:     c = a << b[4:0];
            SRL:     c = a >> b[4:0];
            default: c = '0;
        endcase
    end

    assign zero = (c == '0);

endmodule

// File: rtl/alu_rr_pick.sv
// Round-robin picker: first set bit of req searching upward from ptr+1, wrapping.
// Latency: 0 cycles (combinational).
// Backpressure: none; grant is all-zero when req is empty.
module alu_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic found;
    int   cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin shares one ALU among NUM_REQ requesters; ALU_ARBITER_STATS_EN adds grant counters.
// Latency: result registered, rsp_valid the cycle after req_ready; 1 op/cycle sustained.
// Backpressure: rsp held stable and all req_ready low while rsp_valid && !rsp_ready.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    input  logic [NUM_REQ*3-1:0]    req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_c,
    output logic                    rsp_zero
`ifdef ALU_ARBITER_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [NUM_REQ*16-1:0]   stat_grants
`endif
);

    arb_state_t          state;
    logic [ID_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     win_idx;
    logic                can_accept;
    logic                accept;
    int                  sel;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [OP_W-1:0]     op_code;
    logic [DATA_W-1:0]   alu_c;
    logic                alu_zero;

    // Gating with rstn keeps req_ready low for the whole reset pulse.
    assign can_accept = rstn && ((state == IDLE) || rsp_ready);
    assign accept     = can_accept && (|req_valid);
    assign req_ready  = can_accept ? grant : '0;
    assign rsp_valid  = (state == RESP);

    alu_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    assign sel     = int'(win_idx);
    assign op_a    = req_a[sel*DATA_W +: DATA_W];
    assign op_b    = req_b[sel*DATA_W +: DATA_W];
    assign op_code = req_op[sel*OP_W +: OP_W];

    alu u_alu (
        .alu_op (op_code),
        .a      (op_a),
        .b      (op_b),
        .c      (alu_c),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            rr_ptr   <= ID_W'(NUM_REQ - 1);
            rsp_id   <= '0;
            rsp_c    <= '0;
            rsp_zero <= 1'b0;
        end else if (accept) begin
            state    <= RESP;
            rr_ptr   <= win_idx;
            rsp_id   <= win_idx;
            rsp_c    <= alu_c;
            rsp_zero <= alu_zero;
        end else if (rsp_ready) begin
            state    <= IDLE;
        end
    end

`ifdef ALU_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][15:0] grant_cnt;

    always_ff @(posedge clk) begin
        if (!rstn || stat_clr) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && win_idx == ID_W'(i) && grant_cnt[i] != 16'hFFFF)
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
            end
        end
    end

    assign stat_grants = grant_cnt;
`endif

endmodule
